hdlverifier_capture_ctrl: RTL and testbench
===========================================

Name: hdlverifier_capture_ctrl

Overview:
Sequencer for the HDL Verifier capture path. Takes the combined trigger from the trigger-combine stage, arms on command, fills a circular sample buffer with a programmable pre-trigger window, then writes the post-trigger samples. It generates buffer write strobes and addresses, latches the trigger address, and flags completion to the host-side readout logic.

Parameters:
ADDR_WIDTH, 10, capture buffer address width; DEPTH = 2**ADDR_WIDTH samples
TIMEOUT_WIDTH, 16, width of the trigger-timeout counter (used only with the optional feature)

Ports:
clk  input  1  capture clock
reset_n  input  1  asynchronous active-low reset
clk_enable  input  1  sample qualifier; one sample per cycle with clk_enable=1
start  input  1  arm request pulse; accepted only in IDLE or DONE
abort  input  1  return to IDLE; priority over all other inputs
trigger  input  1  combined trigger, registered upstream
trigger_position  input  ADDR_WIDTH  pre-trigger sample count; latched on accepted start
wr_en  output  1  buffer write strobe
wr_addr  output  ADDR_WIDTH  buffer write address
trigger_addr  output  ADDR_WIDTH  address of the trigger sample
busy  output  1  high in PRETRIG, WAIT_TRIG, POSTTRIG
capture_done  output  1  high in DONE

Behaviour:
- Reset: state=IDLE, wr_addr=0, trigger_addr=0, counters=0, busy=0, capture_done=0. wr_en=0 because the state is IDLE.
- wr_en = clk_enable AND state in {PRETRIG, WAIT_TRIG, POSTTRIG}. wr_en is combinational from registered state. wr_addr increments modulo DEPTH after each write and wraps DEPTH-1 -> 0.
- The sample counter in PRETRIG, and the post counter in POSTTRIG, advance only on write cycles. When clk_enable=0 all state holds.
- IDLE/DONE on start=1:
  - latch trigger_position as P; wr_addr <= 0; clear trigger_addr and capture_done.
  - next state is PRETRIG if P>0, otherwise WAIT_TRIG.
  - start is accepted on any clock edge and does not depend on clk_enable.
- PRETRIG: writes exactly P samples. trigger is ignored. After the P-th write, go to WAIT_TRIG.
- WAIT_TRIG: writes continuously as a circular buffer.
  - The first write cycle with trigger=1 is the trigger sample: trigger_addr <= wr_addr of that write.
  - Post count R = DEPTH-1-P. If R=0, go to DONE; otherwise go to POSTTRIG.
  - A trigger on a cycle with clk_enable=0 is not sampled.
- POSTTRIG: writes R samples. trigger is ignored. After the R-th write, go to DONE.
- DONE: capture_done=1, no writes. State holds until start or abort.
- Totals: writes per capture = P + (writes in WAIT_TRIG including the trigger sample) + R. The last DEPTH writes hold the window, with the trigger sample at offset P from the oldest sample.
- abort=1 forces IDLE on the next edge from any state and clears busy and capture_done. wr_addr and trigger_addr hold. If abort and start are both asserted, abort wins.
- start while busy is ignored. A change on trigger_position while busy has no effect.
- Asynchronous reset mid-capture returns immediately to the reset values. No partial completion is flagged.

Optional Feature:
Macro HDLV_CAPTURE_TRIGGER_TIMEOUT_EN.
- Defined:
  - adds input timeout_cycles [TIMEOUT_WIDTH-1:0] and output timed_out (1 bit).
  - The counter clears on entry to WAIT_TRIG and increments on write cycles in WAIT_TRIG.
  - When the count reaches timeout_cycles (non-zero) without a trigger, that write is treated as the trigger sample and timed_out is set.
  - timed_out clears on accepted start, on abort and on reset.
  - timeout_cycles=0 disables the timeout.
- Undefined: no extra ports or logic; WAIT_TRIG waits indefinitely.

Test Plan:
1. ADDR_WIDTH=4, P=4, clk_enable=1, start, then trigger on the 10th write -> wr_addr 0..9, trigger_addr=9, 11 further writes (addr 10..15, 0..4), capture_done after 21 writes, busy falls in the same cycle.
2. P=4, trigger held high from start -> ignored during the first 4 writes, trigger_addr=4, 11 post writes, done after 16 writes total.
3. P=0 with trigger on write 3 -> trigger_addr=2, 15 post writes. P=15 with trigger on write 16 -> trigger_addr=15, DONE with no POSTTRIG.
4. clk_enable toggling 1/0 during all phases -> write count and addresses identical to scenario 1, only stretched in time; trigger asserted on a clk_enable=0 cycle is not captured.
5. abort mid-POSTTRIG, then reset_n pulsed low mid-WAIT_TRIG -> IDLE next edge, busy=0, capture_done=0, wr_en=0; after reset, wr_addr=0 and trigger_addr=0.
6. With HDLV_CAPTURE_TRIGGER_TIMEOUT_EN, P=2, timeout_cycles=5, no trigger -> forced trigger on the 7th write, trigger_addr=6, timed_out=1, capture_done after 13 more writes. timed_out clears on the next start.

Source files
------------

// File: rtl/hdlverifier_capture_ctrl.sv
// Capture sequencer: arm, pre-trigger fill, trigger wait, post-trigger fill.
// Optional trigger timeout enabled by HDLV_CAPTURE_TRIGGER_TIMEOUT_EN.
module hdlverifier_capture_ctrl #(
  parameter int ADDR_WIDTH    = 10,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_enable,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] trigger_position,
`ifdef HDLV_CAPTURE_TRIGGER_TIMEOUT_EN
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  output logic                     timed_out,
`endif
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] trigger_addr,
  output logic                  busy,
  output logic                  capture_done
);

  if (ADDR_WIDTH < 1 || TIMEOUT_WIDTH < 1) begin : g_param_chk
    $error("hdlverifier_capture_ctrl: widths must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    WAIT_TRIG,
    POSTTRIG,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] taddr_q, taddr_d;
  logic [ADDR_WIDTH-1:0] pos_q, pos_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic                  to_hit;
  logic                  arm;

  assign busy         = (state_q == PRETRIG) ||
                        (state_q == WAIT_TRIG) ||
                        (state_q == POSTTRIG);
  assign capture_done = (state_q == DONE);
  assign wr_en        = clk_enable && busy;
  assign wr_addr      = addr_q;
  assign trigger_addr = taddr_q;
  // Window is DEPTH samples: P before, the trigger, then the rest.
  assign post_cnt     = ~pos_q;
  assign arm          = !abort && start &&
                        ((state_q == IDLE) || (state_q == DONE));

`ifdef HDLV_CAPTURE_TRIGGER_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TONE = 1;

  logic [TIMEOUT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic                     tout_q, tout_d;

  assign to_hit    = (timeout_cycles != '0) &&
                     ((tcnt_q + TONE) == timeout_cycles);
  assign timed_out = tout_q;

  always_comb begin
    tcnt_d = '0;
    tout_d = tout_q;
    if (state_q == WAIT_TRIG) begin
      tcnt_d = wr_en ? tcnt_q + TONE : tcnt_q;
    end
    if (abort || arm) begin
      tout_d = 1'b0;
    end else if (state_q == WAIT_TRIG && wr_en &&
                 !trigger && to_hit) begin
      tout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q <= '0;
      tout_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tout_q <= tout_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    taddr_d = taddr_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            pos_d   = trigger_position;
            addr_d  = '0;
            taddr_d = '0;
            cnt_d   = '0;
            state_d = (trigger_position != '0) ? PRETRIG : WAIT_TRIG;
          end
        end
        PRETRIG: begin
          if (wr_en) begin
            addr_d = addr_q + 1'b1;
            if (cnt_q == pos_q - 1'b1) begin
              cnt_d   = '0;
              state_d = WAIT_TRIG;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        WAIT_TRIG: begin
          if (wr_en) begin
            addr_d = addr_q + 1'b1;
            if (trigger || to_hit) begin
              taddr_d = addr_q;
              cnt_d   = '0;
              state_d = (post_cnt == '0) ? DONE : POSTTRIG;
            end
          end
        end
        POSTTRIG: begin
          if (wr_en) begin
            addr_d = addr_q + 1'b1;
            if (cnt_q == post_cnt - 1'b1) begin
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      taddr_q <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      taddr_q <= taddr_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hdlverifier_capture_ctrl.sv
// Bench for hdlverifier_capture_ctrl (ADDR_WIDTH=4).
// Optional timeout scenario under HDLV_CAPTURE_TRIGGER_TIMEOUT_EN.
module tb_hdlverifier_capture_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clk_enable;
  logic          start;
  logic          abort;
  logic          trigger;
  logic [AW-1:0] trigger_position;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] trigger_addr;
  logic          busy;
  logic          capture_done;
`ifdef HDLV_CAPTURE_TRIGGER_TIMEOUT_EN
  logic [7:0]    timeout_cycles;
  logic          timed_out;
`endif

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  hdlverifier_capture_ctrl #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clk_enable(clk_enable),
    .start(start),
    .abort(abort),
    .trigger(trigger),
    .trigger_position(trigger_position),
`ifdef HDLV_CAPTURE_TRIGGER_TIMEOUT_EN
    .timeout_cycles(timeout_cycles),
    .timed_out(timed_out),
`endif
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .trigger_addr(trigger_addr),
    .busy(busy),
    .capture_done(capture_done)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // p: pre-trigger count, w: 1-based write index of the trigger sample
  task automatic run(input int p, input int w, input bit hold,
                     input bit toggle, input bit fake,
                     input bit bstart, input bit drive);
    int n = 0;
    int total;
    int ta;
    bit done_seen = 0;
    bit prev_wr = 0;
    bit ce;
    logic [31:0] r;
    logic [31:0] pv;
    if (hold) w = p + 1;
    total = w + DEPTH - 1 - p;
    ta = (w - 1) % DEPTH;
    exp_q.delete();
    for (int i = 0; i < total; i++) exp_q.push_back(i % DEPTH);
    pv = p;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    trigger_position = pv[AW-1:0];
    clk_enable = !toggle;
    trigger = hold;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      ce = toggle ? (c % 2 == 0) : 1'b1;
      clk_enable = ce;
      trigger = hold | (drive && n == w - 1) |
                (fake && !ce && n == p + 1);
      start = bstart && n == 2;
      r = $urandom;
      trigger_position = r[AW-1:0];
      #1;
      if (capture_done) begin
        done_seen = 1;
        check("done_after_last_write", prev_wr, 1);
        check("busy_at_done", busy, 0);
        check("wr_en_at_done", wr_en, 0);
      end else begin
        check("busy", busy, 1);
        check("wr_en", wr_en, ce);
        if (wr_en) begin
          check("write_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("wr_addr", wr_addr, exp_q.pop_front());
          n++;
        end
        prev_wr = wr_en;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("capture_done_reached", done_seen, 1);
    check("writes_left", exp_q.size(), 0);
    check("write_count", n, total);
    check("trigger_addr", trigger_addr, ta);
    clk_enable = 1'b1;
    trigger = 1'b1;
    #1;
    check("done_no_write", wr_en, 0);
    @(negedge clk);
    #1;
    check("done_holds", capture_done, 1);
    trigger = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    clk_enable = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    trigger = 1'b0;
    trigger_position = '0;
`ifdef HDLV_CAPTURE_TRIGGER_TIMEOUT_EN
    timeout_cycles = '0;
`endif
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_trigger_addr", trigger_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", capture_done, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run(4, 10, 0, 0, 0, 1, 1);
    run(4, 1, 1, 0, 0, 0, 1);
    run(0, 3, 0, 0, 0, 0, 1);
    run(15, 16, 0, 0, 0, 0, 1);
    run(4, 10, 0, 1, 1, 0, 1);

    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_from_done", capture_done, 0);

    @(negedge clk);
    start = 1'b1;
    trigger_position = 4'd4;
    clk_enable = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 12; c++) begin
      trigger = (n == 5);
      #1;
      if (wr_en) n++;
      @(negedge clk);
    end
    trigger = 1'b0;
    check("pre_abort_busy", busy, 1);
    abort = 1'b1;
    start = 1'b1;
    clk_enable = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", capture_done, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_wr_addr", wr_addr, 12);
    check("abort_trigger_addr", trigger_addr, 5);
    clk_enable = 1'b1;
    @(negedge clk);
    #1;
    check("idle_wr_en", wr_en, 0);

    start = 1'b1;
    trigger_position = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("reset_wr_addr", wr_addr, 0);
    check("reset_trigger_addr", trigger_addr, 0);
    check("reset_busy", busy, 0);
    check("reset_done", capture_done, 0);
    check("reset_wr_en", wr_en, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset_wr_en", wr_en, 0);

`ifdef HDLV_CAPTURE_TRIGGER_TIMEOUT_EN
    timeout_cycles = 8'd5;
    run(2, 7, 0, 0, 0, 0, 0);
    check("timed_out_set", timed_out, 1);
    timeout_cycles = 8'd0;
    run(3, 5, 0, 0, 0, 0, 1);
    check("timed_out_cleared", timed_out, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
